mips_fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS core, directly upstream of the combinational instruction RAM. It owns the program counter, drives `instr_address`, captures `instr_readdata` in the same cycle, and queues {pc, instr} pairs in a 2-entry buffer toward decode under valid/ready handshake. It honours MIPS branch-delay-slot semantics on redirects and stops fetching once the PC reaches the halt address.

---
 rtl/mips_fetch_pkg.sv | 13 +
 rtl/mips_fetch_unit_if.sv | 41 ++++
 rtl/fetch_buffer.sv | 54 +++++
 rtl/mips_fetch_unit.sv | 71 +++++++
 tb/tb_mips_fetch_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
  localparam int unsigned DEPTH        = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: instruction RAM port, decode handshake, redirect and status.
interface mips_fetch_unit_if;

  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;
  logic        idle;

  modport master (
    output instr_address,
    input  instr_readdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_target,
    output halted,
    output idle
  );

  modport slave (
    input  instr_address,
    output instr_readdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_target,
    input  halted,
    input  idle
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; pop, then flush-keep-oldest, then push.
module fetch_buffer
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush_keep_oldest,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   cnt;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    cnt      = count_q;
    if (pop && cnt != 2'd0) begin
      entry0_d = entry1_q;
      cnt      = cnt - 2'd1;
    end
    if (flush_keep_oldest && cnt > 2'd1) begin
      cnt = 2'd1;
    end
    if (push) begin
      if (cnt == 2'd0) entry0_d = push_entry;
      else             entry1_d = push_entry;
      cnt = cnt + 2'd1;
    end
    count_d = cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: PC register, delay-slot-aware redirect, halt detection, 2-deep buffer.
module mips_fetch_unit
  import mips_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mips_fetch_unit_if.master  bus
);

  localparam logic [1:0] Full = 2'(DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic         halted_q;
  logic [1:0]   count;
  logic [1:0]   count_after_pop;
  logic         pop;
  logic         push;
  logic         flush;
  fetch_entry_t head;
  fetch_entry_t fetched;

  assign pop             = (count != 2'd0) && bus.out_ready;
  assign count_after_pop = count - {1'b0, pop};
  assign fetched         = '{pc: pc_q, instr: bus.instr_readdata};

  // A surviving entry is the delay slot; otherwise this cycle's fetch becomes it.
  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    flush = 1'b0;
    if (!halted_q) begin
      if (bus.redirect_valid) begin
        pc_d = bus.redirect_target;
        if (count_after_pop != 2'd0) flush = 1'b1;
        else                         push  = 1'b1;
      end else if (count_after_pop != Full) begin
        push = 1'b1;
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_VECTOR;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= (pc_d == HALT_ADDR);
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk               (clk),
    .reset_n           (reset_n),
    .push              (push),
    .push_entry        (fetched),
    .pop               (pop),
    .flush_keep_oldest (flush),
    .count             (count),
    .head              (head)
  );

  assign bus.instr_address = pc_q;
  assign bus.out_valid     = (count != 2'd0);
  assign bus.out_instr     = head.instr;
  assign bus.out_pc        = head.pc;
  assign bus.halted        = halted_q;
  assign bus.idle          = halted_q && (count == 2'd0);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized + directed bench for mips_fetch_unit against a queue-based reference model.
module tb_mips_fetch_unit;

  localparam logic [31:0] ResetVec = 32'hBFC0_0000;
  localparam logic [31:0] HaltAddr = 32'h0000_0000;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mips_fetch_unit_if bus ();

  mips_fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  always_comb bus.instr_readdata = ram_word(bus.instr_address);

  // Reference model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = ResetVec;
    m_halted = 1'b0;
    q_pc.delete();
    q_instr.delete();
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    @(negedge clk);
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    #1;
    check("instr_address", bus.instr_address, m_pc);
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, q_pc.size() != 0});
    if (q_pc.size() != 0) begin
      check("out_pc", bus.out_pc, q_pc[0]);
      check("out_instr", bus.out_instr, q_instr[0]);
    end
    check("halted", {31'b0, bus.halted}, {31'b0, m_halted});
    check("idle", {31'b0, bus.idle}, {31'b0, m_halted && q_pc.size() == 0});
    if (rdy && q_pc.size() != 0) begin
      void'(q_pc.pop_front());
      void'(q_instr.pop_front());
    end
    if (!m_halted) begin
      if (rv) begin
        if (q_pc.size() >= 1) begin
          while (q_pc.size() > 1) begin
            void'(q_pc.pop_back());
            void'(q_instr.pop_back());
          end
        end else begin
          q_pc.push_back(m_pc);
          q_instr.push_back(ram_word(m_pc));
        end
        m_pc = tgt;
      end else if (q_pc.size() < 2) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(ram_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
      m_halted = (m_pc == HaltAddr);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_instr_address", bus.instr_address, ResetVec);
    check("rst_halted", {31'b0, bus.halted}, 32'd0);
    check("rst_idle", {31'b0, bus.idle}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    errors              = 0;
    checks              = 0;
    reset_n             = 1'b0;
    bus.out_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    model_reset();
    #1;
    check("init_out_pc", bus.out_pc, 32'd0);
    check("init_out_instr", bus.out_instr, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Streaming from the reset vector
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    // Back-pressure then release
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    // Full buffer: pop + redirect keeps only the delay slot
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'hBFC0_0100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    // Single entry popped: this cycle's fetch is the delay slot
    cycle(1'b1, 1'b1, 32'hBFC0_0200);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    // Unaligned target low bits forwarded as-is
    cycle(1'b1, 1'b1, 32'h8000_1002);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom & 32'h7FFF_FFFC) | 32'h0000_1000;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, tgt);
    end

    // Reset mid-stream with a full buffer
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);

    // Jump to the halt address, drain, then redirects are ignored
    cycle(1'b1, 1'b1, HaltAddr);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    check("halt_pc", bus.instr_address, HaltAddr);
    cycle(1'b1, 1'b1, 32'hBFC0_0300);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    check("halt_idle", {31'b0, bus.idle}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
